// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with registered reads, write bypass and optional zero register.
module reg_file_mp #(
  parameter int n        = 32,
  parameter int r        = 7,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NW-1:0]   regWrite,
  input  logic [NW*r-1:0] writeReg,
  input  logic [NW*n-1:0] writeData,
  input  logic [NR-1:0]   readEn,
  input  logic [NR*r-1:0] readReg,
  output logic [NR*n-1:0] readData,
  output logic [NR-1:0]   readValid
);
  localparam int D = 2**r;
  logic [n-1:0]    words_q [D];
  logic [D-1:0]    written_q, written_d;
  logic [NW-1:0]   wr_ok;
  logic [NR*n-1:0] rdata_q, rdata_d;
  logic [NR-1:0]   valid_q;
  // Writes to register 0 are squashed here, so neither storage nor bypass ever sees them.
  always_comb begin
    wr_ok = '0;
    for (int k = 0; k < NW; k++)
      wr_ok[k] = regWrite[k] && !(ZERO_REG != 0 && writeReg[k*r +: r] == '0);
  end
  always_comb begin
    written_d = written_q;
    for (int k = 0; k < NW; k++)
      if (wr_ok[k]) written_d[writeReg[k*r +: r]] = 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) written_q <= '0;
    else written_q <= written_d;
  // Ascending port order lets the highest-index writer win a conflict.
  always_ff @(posedge clk)
    if (!reset)
      for (int k = 0; k < NW; k++)
        if (wr_ok[k]) words_q[writeReg[k*r +: r]] <= writeData[k*n +: n];
  always_comb begin
    logic [r-1:0] a;
    logic [n-1:0] v;
    a = '0;
    v = '0;
    rdata_d = rdata_q;
    for (int j = 0; j < NR; j++)
      if (readEn[j]) begin
        a = readReg[j*r +: r];
        v = written_q[a] ? words_q[a] : '0;
        if (BYPASS != 0)
          for (int k = 0; k < NW; k++)
            if (wr_ok[k] && writeReg[k*r +: r] == a) v = writeData[k*n +: n];
        rdata_d[j*n +: n] = v;
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rdata_q <= '0;
      valid_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      valid_q <= readEn;
    end
  assign readData  = rdata_q;
  assign readValid = valid_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: random and directed checks of two reg_file_mp configurations against a memory-array model.
module tb_reg_file_mp;
  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   regWrite;
  logic [9:0]   writeReg;
  logic [127:0] writeData;
  logic [3:0]   readEn;
  logic [19:0]  readReg;
  logic [255:0] rdata_a, rdata_b;
  logic [3:0]   rvalid_a, rvalid_b;
  logic [63:0]  mem_a [32], mem_b [32];
  logic [63:0]  exp_a [4], exp_b [4];
  logic [3:0]   exp_v;
  int checks = 0, errors = 0;

  reg_file_mp #(.n(64), .r(5), .NR(4), .NW(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .readEn(readEn), .readReg(readReg), .readData(rdata_a), .readValid(rvalid_a));
  reg_file_mp #(.n(64), .r(5), .NR(4), .NW(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .readEn(readEn), .readReg(readReg), .readData(rdata_b), .readValid(rvalid_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    for (int j = 0; j < 4; j++) begin
      exp_a[j] = '0;
      exp_b[j] = '0;
    end
    exp_v = '0;
  endtask

  task automatic check_outputs();
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("a_data%0d", j), rdata_a[j*64 +: 64], exp_a[j]);
      chk($sformatf("b_data%0d", j), rdata_b[j*64 +: 64], exp_b[j]);
      chk($sformatf("a_valid%0d", j), 64'(rvalid_a[j]), 64'(exp_v[j]));
      chk($sformatf("b_valid%0d", j), 64'(rvalid_b[j]), 64'(exp_v[j]));
    end
  endtask

  // Predict from current inputs, clock once, then commit writes to the model.
  task automatic step();
    logic [4:0]  a;
    logic [63:0] v;
    for (int j = 0; j < 4; j++)
      if (readEn[j]) begin
        a = readReg[j*5 +: 5];
        v = mem_a[a];
        for (int k = 0; k < 2; k++)
          if (regWrite[k] && writeReg[k*5 +: 5] == a) v = writeData[k*64 +: 64];
        exp_a[j] = (a == 0) ? 64'd0 : v;
        exp_b[j] = mem_b[a];
      end
    exp_v = readEn;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      if (regWrite[k]) begin
        a = writeReg[k*5 +: 5];
        if (a != 0) mem_a[a] = writeData[k*64 +: 64];
        mem_b[a] = writeData[k*64 +: 64];
      end
    check_outputs();
  endtask

  task automatic idle();
    regWrite = '0;
    writeReg = '0;
    writeData = '0;
    readEn = '0;
    readReg = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    #11 reset = 1'b0;
    readEn = 4'b0001; readReg[4:0] = 5'd5;
    step();
    readEn = '0;
    step();
    regWrite = 2'b01; writeReg[4:0] = 5'd12; writeData[63:0] = 64'hDEADBEEF;
    step();
    idle(); readEn = 4'b0011; readReg[9:0] = {5'd12, 5'd12};
    step();
    readEn = '0;
    step();
    idle(); regWrite = 2'b01; writeReg[4:0] = 5'd3; writeData[63:0] = 64'h12345678;
    readEn = 4'b0001; readReg[4:0] = 5'd3;
    step();
    idle(); regWrite = 2'b11; writeReg = {5'd7, 5'd7}; writeData = {64'h5555, 64'hAAAA};
    step();
    idle(); readEn = 4'b1111; readReg = {5'd7, 5'd3, 5'd7, 5'd12};
    step();
    idle(); regWrite = 2'b10; writeReg[9:5] = 5'd0; writeData[127:64] = 64'hFFFF;
    readEn = 4'b0100; readReg[14:10] = 5'd0;
    step();
    idle(); readEn = 4'b0100;
    step();
    idle(); regWrite = 2'b01; writeReg[4:0] = 5'd9; writeData[63:0] = 64'h1;
    step();
    idle(); readEn = 4'b0001; readReg[4:0] = 5'd9;
    step();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    regWrite = 2'b01; writeReg[4:0] = 5'd9; writeData[63:0] = 64'h77;
    @(posedge clk);
    #1 idle();
    #2 reset = 1'b0;
    readEn = 4'b0001; readReg[4:0] = 5'd9;
    step();
    for (int i = 0; i < 400; i++) begin
      regWrite = 2'($urandom);
      readEn = 4'($urandom);
      for (int k = 0; k < 2; k++) begin
        writeReg[k*5 +: 5] = 5'((i % 2) ? $urandom_range(0, 31) : $urandom_range(0, 5));
        writeData[k*64 +: 64] = {$urandom, $urandom};
      end
      for (int j = 0; j < 4; j++)
        readReg[j*5 +: 5] = 5'((i % 2) ? $urandom_range(0, 31) : $urandom_range(0, 5));
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
